// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the on-chip memory BIST: FSM states, pattern
// modes, LFSR feedback taps and checkerboard words.
package onchip_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GAP,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } bist_state_e;

    typedef enum logic [1:0] {
        MODE_LFSR     = 2'b00,
        MODE_ADDR     = 2'b01,
        MODE_CHECKER  = 2'b10,
        MODE_LFSR_ALT = 2'b11
    } bist_mode_e;

    // Taps for x^32+x^22+x^2+x+1 in a left-shifting Fibonacci register
    localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
    localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

    localparam logic [31:0] CHECKER_EVEN = 32'h5555_5555;
    localparam logic [31:0] CHECKER_ODD  = 32'hAAAA_AAAA;

    function automatic logic [31:0] lfsr_next(input logic [31:0] q);
        return {q[30:0], ^(q & LFSR_POLY)};
    endfunction

endpackage

// File: rtl/onchip_mem_bist_if.sv
// Single-port RAM bus between the BIST engine (master) and the memory (slave).
interface onchip_mem_bist_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) ();

    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    modport master (output en, we, addr, din, input dout);
    modport slave  (input en, we, addr, din, output dout);

endinterface

// File: rtl/bist_lfsr32.sv
// 32-bit Fibonacci LFSR pattern source; load has priority over advance.
module bist_lfsr32
    import onchip_mem_pkg::*;
(
    input  logic        i_sys_clk,
    input  logic        i_rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] q
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            q <= LFSR_RESET;
        end else if (load) begin
            q <= seed;
        end else if (advance) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/onchip_mem_bist.sv
// March-style write-then-read memory BIST with selectable data patterns,
// read-latency-matched compare pipeline, saturating error count and first-fail capture.
module onchip_mem_bist
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int GAP_CYCLES = 32,
    parameter int ERR_W      = 16
) (
    input  logic                 i_sys_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [1:0]           i_mode,
    input  logic [31:0]          i_seed,
    onchip_mem_bist_if.master    mem,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [ERR_W-1:0]     o_err_cnt,
    output logic [ADDR_W-1:0]    o_first_err_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam int                WAIT_W     = $clog2(GAP_CYCLES + 1);
    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(GAP_CYCLES - 1);
    localparam logic [WAIT_W-1:0] DRAIN_LAST = WAIT_W'(RD_LAT - 1);

    bist_state_e         state_q, state_d;
    bist_mode_e          mode_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [31:0]         seed_q;
    logic [ERR_W-1:0]    err_q;
    logic [ADDR_W-1:0]   first_q;
    logic                pass_q;

    logic                mem_en, mem_we;
    logic                lfsr_load, lfsr_adv;
    logic [31:0]         lfsr_q, lfsr_seed, start_seed;
    logic                abort_now, rd_issue, mismatch;
    logic [DATA_W-1:0]   pattern;

    logic [RD_LAT-1:0]   vld_q;
    logic [DATA_W-1:0]   exp_q   [RD_LAT];
    logic [ADDR_W-1:0]   eaddr_q [RD_LAT];

    assign start_seed = (i_seed == 32'h0) ? LFSR_RESET : i_seed;
    assign lfsr_seed  = (state_q == ST_IDLE) ? start_seed : seed_q;
    assign abort_now  = i_abort && (state_q != ST_IDLE);

    bist_lfsr32 u_lfsr (
        .i_sys_clk (i_sys_clk),
        .i_rst     (i_rst),
        .load      (lfsr_load),
        .seed      (lfsr_seed),
        .advance   (lfsr_adv),
        .q         (lfsr_q)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    state_d   = ST_WRITE;
                    lfsr_load = 1'b1;
                end
            end
            ST_WRITE: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                lfsr_adv = 1'b1;
                if (addr_q == LAST_ADDR) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (wait_q == GAP_LAST) begin
                    state_d   = ST_READ;
                    lfsr_load = 1'b1;
                end
            end
            ST_READ: begin
                mem_en   = 1'b1;
                lfsr_adv = 1'b1;
                if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wait_q == DRAIN_LAST) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_now) begin
            state_d   = ST_IDLE;
            lfsr_load = 1'b0;
            lfsr_adv  = 1'b0;
        end
    end

    // The same word is the write data in WRITE and the expected value in READ
    always_comb begin
        case (mode_q)
            MODE_ADDR:    pattern = DATA_W'(addr_q);
            MODE_CHECKER: pattern = addr_q[0] ? CHECKER_ODD[DATA_W-1:0] : CHECKER_EVEN[DATA_W-1:0];
            default:      pattern = lfsr_q[DATA_W-1:0];
        endcase
    end

    assign rd_issue = mem_en && !mem_we;
    assign mismatch = vld_q[RD_LAT-1] && (mem.dout != exp_q[RD_LAT-1]) && !abort_now;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LFSR;
            addr_q  <= '0;
            wait_q  <= '0;
            seed_q  <= LFSR_RESET;
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= (state_d == state_q && (state_q == ST_GAP || state_q == ST_DRAIN))
                       ? wait_q + WAIT_W'(1) : '0;
            addr_q  <= (mem_en && state_d == state_q) ? addr_q + ADDR_W'(1) : '0;

            if (state_q == ST_IDLE && state_d == ST_WRITE) begin
                mode_q  <= bist_mode_e'(i_mode);
                seed_q  <= start_seed;
                err_q   <= '0;
                first_q <= '0;
                pass_q  <= 1'b0;
            end

            if (mismatch) begin
                if (err_q != '1) err_q <= err_q + ERR_W'(1);
                if (err_q == '0) first_q <= eaddr_q[RD_LAT-1];
            end

            if (state_q == ST_DONE) pass_q <= (err_q == '0);
            if (abort_now) pass_q <= 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst || abort_now) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    // NOTE: the pipeline data words are not reset; vld_q alone decides whether they are looked at.
    always_ff @(posedge i_sys_clk) begin
        exp_q[0]   <= pattern;
        eaddr_q[0] <= addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            exp_q[i]   <= exp_q[i-1];
            eaddr_q[i] <= eaddr_q[i-1];
        end
    end

    assign mem.en           = mem_en;
    assign mem.we           = mem_we;
    assign mem.addr         = addr_q;
    assign mem.din          = mem_we ? pattern : '0;
    assign o_busy           = (state_q != ST_IDLE);
    assign o_done           = (state_q == ST_DONE);
    assign o_pass           = (state_q == ST_DONE) ? (err_q == '0) : pass_q;
    assign o_err_cnt        = err_q;
    assign o_first_err_addr = first_q;

endmodule

// File: tb/tb_onchip_mem_bist.sv
// Directed bench for onchip_mem_bist: three DUT builds (default, RD_LAT=2, ERR_W=4)
// each against its own behavioural RAM.
module tb_onchip_mem_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  start_v = '0;
    logic [2:0]  abort_v = '0;
    logic [1:0]  mode_v [3];
    logic [31:0] seed_v [3];
    logic [2:0]  busy_v, done_v, pass_v;
    logic [15:0] err_a, err_b;
    logic [3:0]  err_c;
    logic [7:0]  first_a, first_b, first_c;

    onchip_mem_bist_if #(.DATA_W(16), .ADDR_W(8)) mem_a ();
    onchip_mem_bist_if #(.DATA_W(16), .ADDR_W(8)) mem_b ();
    onchip_mem_bist_if #(.DATA_W(16), .ADDR_W(8)) mem_c ();

    onchip_mem_bist u_dut_a (
        .i_sys_clk(clk), .i_rst(rst), .i_start(start_v[0]), .i_abort(abort_v[0]),
        .i_mode(mode_v[0]), .i_seed(seed_v[0]), .mem(mem_a),
        .o_busy(busy_v[0]), .o_done(done_v[0]), .o_pass(pass_v[0]),
        .o_err_cnt(err_a), .o_first_err_addr(first_a)
    );

    onchip_mem_bist #(.RD_LAT(2)) u_dut_b (
        .i_sys_clk(clk), .i_rst(rst), .i_start(start_v[1]), .i_abort(abort_v[1]),
        .i_mode(mode_v[1]), .i_seed(seed_v[1]), .mem(mem_b),
        .o_busy(busy_v[1]), .o_done(done_v[1]), .o_pass(pass_v[1]),
        .o_err_cnt(err_b), .o_first_err_addr(first_b)
    );

    onchip_mem_bist #(.ERR_W(4)) u_dut_c (
        .i_sys_clk(clk), .i_rst(rst), .i_start(start_v[2]), .i_abort(abort_v[2]),
        .i_mode(mode_v[2]), .i_seed(seed_v[2]), .mem(mem_c),
        .o_busy(busy_v[2]), .o_done(done_v[2]), .o_pass(pass_v[2]),
        .o_err_cnt(err_c), .o_first_err_addr(first_c)
    );

    // RAM A: 1-cycle read latency, optional bit-3 stuck-at-1 at 8'h10
    logic [15:0] ram_a [256];
    logic        stuck_a = 1'b0;
    always @(posedge clk) begin
        if (mem_a.en) begin
            if (mem_a.we) ram_a[mem_a.addr] <= mem_a.din;
            else mem_a.dout <= ram_a[mem_a.addr] |
                               ((stuck_a && mem_a.addr == 8'h10) ? 16'h0008 : 16'h0000);
        end
    end
    assign mem_b.dout = 16'h0000;
    assign mem_c.dout = 16'hFFFF;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_lfsr_step(input logic [31:0] q);
        return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
    endfunction

    // Leaves the bench at the negedge of cycle 1 (start sampled at edge 0)
    task automatic start_bist(input int k, input logic [1:0] m, input logic [31:0] s);
        @(negedge clk);
        mode_v[k]  = m;
        seed_v[k]  = s;
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int c0, output int cyc);
        cyc = c0;
        while (!done_v[k] && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int          cyc;
    int          cnt;
    logic        seen_done;
    logic [31:0] lf;

    initial begin
        for (int i = 0; i < 3; i++) begin
            mode_v[i] = 2'b00;
            seed_v[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy_v),  32'h0);
        check("rst_done",  32'(done_v),  32'h0);
        check("rst_pass",  32'(pass_v),  32'h0);
        check("rst_err",   32'(err_a),   32'h0);
        check("rst_first", 32'(first_a), 32'h0);
        check("rst_en_we", {30'h0, mem_a.en, mem_a.we}, 32'h0);
        check("rst_addr",  32'(mem_a.addr), 32'h0);
        check("rst_din",   32'(mem_a.din),  32'h0);
        rst = 1'b0;

        // LFSR mode, fault-free
        start_bist(0, 2'b00, 32'hACE1);
        check("wr0_en_we", {30'h0, mem_a.en, mem_a.we}, 32'h3);
        check("wr0_addr",  32'(mem_a.addr), 32'h0);
        check("wr0_din",   32'(mem_a.din),  32'hACE1);
        check("wr0_busy",  32'(busy_v[0]),  32'h1);
        repeat (256) @(negedge clk);
        check("gap_en", {30'h0, mem_a.en, mem_a.we}, 32'h0);
        repeat (32) @(negedge clk);
        check("rd0_en_we", {30'h0, mem_a.en, mem_a.we}, 32'h2);
        check("rd0_addr",  32'(mem_a.addr), 32'h0);
        wait_done(0, 289, cyc);
        check("lfsr_done_cyc", 32'(cyc), 32'd546);
        check("lfsr_pass", 32'(pass_v[0]), 32'h1);
        check("lfsr_err",  32'(err_a), 32'h0);
        check("lfsr_ram0", 32'(ram_a[0]), 32'hACE1);
        check("lfsr_ram1", 32'(ram_a[1]), 32'h59C3);
        lf = 32'hACE1;
        for (int i = 0; i < 255; i++) lf = ref_lfsr_step(lf);
        check("lfsr_ram255", 32'(ram_a[255]), {16'h0, lf[15:0]});
        @(negedge clk);
        check("done_pulse", 32'(done_v[0]), 32'h0);
        check("pass_held",  32'(pass_v[0]), 32'h1);
        check("idle_busy",  32'(busy_v[0]), 32'h0);

        // Address mode, bit 3 stuck-at-1 at 8'h10
        stuck_a = 1'b1;
        start_bist(0, 2'b01, 32'h1234);
        check("addr_din0", 32'(mem_a.din), 32'h0);
        wait_done(0, 1, cyc);
        check("stuck_done_cyc", 32'(cyc), 32'd546);
        check("stuck_pass",  32'(pass_v[0]), 32'h0);
        check("stuck_err",   32'(err_a),   32'h1);
        check("stuck_first", 32'(first_a), 32'h10);
        check("stuck_ram10", 32'(ram_a[8'h10]), 32'h0010);
        stuck_a = 1'b0;

        // Checkerboard, RD_LAT=2, reads always 0
        start_bist(1, 2'b10, 32'h0);
        check("chk_din0", 32'(mem_b.din), 32'h5555);
        @(negedge clk);
        check("chk_din1", 32'(mem_b.din), 32'hAAAA);
        wait_done(1, 2, cyc);
        check("lat2_done_cyc", 32'(cyc), 32'd547);
        check("lat2_err",   32'(err_b),   32'd256);
        check("lat2_first", 32'(first_b), 32'h0);
        check("lat2_pass",  32'(pass_v[1]), 32'h0);

        // Abort during READ at address 100, then a clean run with a stray start mid-test
        start_bist(0, 2'b00, 32'hACE1);
        cnt = 0;
        while (!(mem_a.en && !mem_a.we && mem_a.addr == 8'd100) && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("abort_reach", 32'(mem_a.addr), 32'd100);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        check("abort_busy",  32'(busy_v[0]), 32'h0);
        check("abort_en_we", {30'h0, mem_a.en, mem_a.we}, 32'h0);
        check("abort_pass",  32'(pass_v[0]), 32'h0);
        check("abort_err",   32'(err_a), 32'h0);
        seen_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            seen_done |= done_v[0];
        end
        check("abort_no_done", 32'(seen_done), 32'h0);
        start_bist(0, 2'b00, 32'hACE1);
        repeat (9) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 11, cyc);
        check("rerun_done_cyc", 32'(cyc), 32'd546);
        check("rerun_pass", 32'(pass_v[0]), 32'h1);

        // Reset in GAP, then seed 0 falls back to 1
        start_bist(0, 2'b00, 32'hBEEF);
        repeat (269) @(negedge clk);
        check("gap_busy", 32'(busy_v[0]), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("grst_busy",  32'(busy_v[0]), 32'h0);
        check("grst_pass",  32'(pass_v[0]), 32'h0);
        check("grst_done",  32'(done_v[0]), 32'h0);
        check("grst_en_we", {30'h0, mem_a.en, mem_a.we}, 32'h0);
        check("grst_addr",  32'(mem_a.addr), 32'h0);
        start_bist(0, 2'b00, 32'h0);
        check("seed0_din0", 32'(mem_a.din), 32'h0001);
        wait_done(0, 1, cyc);
        check("seed0_done_cyc", 32'(cyc), 32'd546);
        check("seed0_pass", 32'(pass_v[0]), 32'h1);
        check("seed0_ram1", 32'(ram_a[1]), 32'h0003);

        // ERR_W=4, all-ones RAM, address mode: counter saturates
        start_bist(2, 2'b01, 32'h5);
        wait_done(2, 1, cyc);
        check("sat_done_cyc", 32'(cyc), 32'd546);
        check("sat_err",   32'(err_c),   32'd15);
        check("sat_first", 32'(first_c), 32'h0);

        // Abort and start together in IDLE: abort wins
        @(negedge clk);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        check("abort_start_busy", 32'(busy_v[0]), 32'h0);
        check("abort_start_en",   32'(mem_a.en),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
